// File: rtl/sobel_frame_seq.sv
// Frame sequencer for a Sobel edge filter: gray pass, then a raster pass.
// Each interior pixel gets nine 3x3 window taps. Each border pixel gets a single direct write.
module sobel_frame_seq #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [9:0] gray_rd_addr,
    output logic       gray_wr_en,
    output logic [9:0] gray_wr_addr,
    output logic       win_rd_en,
    output logic [9:0] win_rd_addr,
    output logic       tap_valid,
    output logic [3:0] tap_idx,
    output logic       pix_wr_en,
    output logic [9:0] pix_wr_addr,
    output logic       border,
    output logic       busy,
    output logic       done,
    output logic [1:0] phase
);

    localparam logic [9:0] W10    = 10'(IMG_W);
    localparam logic [9:0] LAST_C = 10'(IMG_W - 1);
    localparam logic [9:0] LAST_R = 10'(IMG_H - 1);
    localparam logic [9:0] LAST_P = 10'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GRAY, S_GRAY_DRAIN, S_SOB_TAP, S_SOB_WAIT, S_SOB_WR, S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [9:0] k, r, c, pix;
    logic [9:0] r_adv, c_adv;
    logic [3:0] t;
    logic       gwr_vld_p1, tap_vld_p1;
    logic [9:0] gwr_addr_p1;
    logic [3:0] tap_idx_p1;

    function automatic logic on_border(input logic [9:0] rr, input logic [9:0] cc);
        return (rr == 10'd0) || (rr == LAST_R) || (cc == 10'd0) || (cc == LAST_C);
    endfunction

    // Tap t sits at (dr, dc) = (t/3 - 1, t%3 - 1) around pixel p.
    function automatic logic [9:0] tap_addr(input logic [9:0] p, input logic [3:0] tt);
        logic [9:0] row;
        case (tt)
            4'd0, 4'd1, 4'd2: row = p - W10;
            4'd3, 4'd4, 4'd5: row = p;
            default:          row = p + W10;
        endcase
        case (tt)
            4'd0, 4'd3, 4'd6: return row - 10'd1;
            4'd1, 4'd4, 4'd7: return row;
            default:          return row + 10'd1;
        endcase
    endfunction

    always_comb begin
        c_adv = (c == LAST_C) ? 10'd0 : c + 10'd1;
        r_adv = (c == LAST_C) ? r + 10'd1 : r;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (start) state_nxt = S_GRAY;
            S_GRAY:       if (k == LAST_P) state_nxt = S_GRAY_DRAIN;
            S_GRAY_DRAIN: state_nxt = on_border(10'd0, 10'd0) ? S_SOB_WR : S_SOB_TAP;
            S_SOB_TAP:    if (t == 4'd8) state_nxt = S_SOB_WAIT;
            S_SOB_WAIT:   state_nxt = S_SOB_WR;
            S_SOB_WR: begin
                if (pix == LAST_P)                state_nxt = S_DONE;
                else if (on_border(r_adv, c_adv)) state_nxt = S_SOB_WR;
                else                              state_nxt = S_SOB_TAP;
            end
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    // p0 -> p1: read data returns one cycle after each issued address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k           <= '0;
            t           <= '0;
            r           <= '0;
            c           <= '0;
            pix         <= '0;
            gwr_vld_p1  <= 1'b0;
            gwr_addr_p1 <= '0;
            tap_vld_p1  <= 1'b0;
            tap_idx_p1  <= '0;
        end else begin
            gwr_vld_p1  <= (state == S_GRAY) && !abort;
            gwr_addr_p1 <= k;
            tap_vld_p1  <= (state == S_SOB_TAP) && !abort;
            tap_idx_p1  <= t;
            k <= (state == S_GRAY) ? k + 10'd1 : 10'd0;
            t <= (state == S_SOB_TAP && t != 4'd8) ? t + 4'd1 : 4'd0;
            if (state == S_SOB_WR) begin
                r   <= r_adv;
                c   <= c_adv;
                pix <= pix + 10'd1;
            end else if (state != S_SOB_TAP && state != S_SOB_WAIT) begin
                r   <= '0;
                c   <= '0;
                pix <= '0;
            end
        end
    end

    always_comb begin
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        gray_rd_addr = (state == S_GRAY) ? k : 10'd0;
        gray_wr_en   = gwr_vld_p1;
        gray_wr_addr = gwr_addr_p1;
        win_rd_en    = (state == S_SOB_TAP);
        win_rd_addr  = (state == S_SOB_TAP) ? tap_addr(pix, t) : 10'd0;
        tap_valid    = tap_vld_p1;
        tap_idx      = tap_idx_p1;
        pix_wr_en    = (state == S_SOB_WR);
        pix_wr_addr  = (state == S_SOB_WR) ? pix : 10'd0;
        border       = (state == S_SOB_WR) && on_border(r, c);
        case (state)
            S_IDLE:                            phase = 2'd0;
            S_GRAY, S_GRAY_DRAIN:              phase = 2'd1;
            S_SOB_TAP, S_SOB_WAIT, S_SOB_WR:   phase = 2'd2;
            default:                           phase = 2'd3;
        endcase
    end

endmodule

// File: tb/tb_sobel_frame_seq.sv
// Randomized bench for sobel_frame_seq: the 32x32 and 8x4 instances share their stimulus.
// Both are checked each cycle against frame traces built from nested pixel loops.
module tb_sobel_frame_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] grd_a, gwa_a, wra_a, pwa_a, grd_b, gwa_b, wra_b, pwa_b;
    logic       gwe_a, wre_a, tv_a, pwe_a, bord_a, busy_a, done_a;
    logic       gwe_b, wre_b, tv_b, pwe_b, bord_b, busy_b, done_b;
    logic [3:0] ti_a, ti_b;
    logic [1:0] ph_a, ph_b;

    sobel_frame_seq dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gray_rd_addr(grd_a), .gray_wr_en(gwe_a), .gray_wr_addr(gwa_a),
        .win_rd_en(wre_a), .win_rd_addr(wra_a), .tap_valid(tv_a), .tap_idx(ti_a),
        .pix_wr_en(pwe_a), .pix_wr_addr(pwa_a), .border(bord_a),
        .busy(busy_a), .done(done_a), .phase(ph_a)
    );

    sobel_frame_seq #(.IMG_W(8), .IMG_H(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gray_rd_addr(grd_b), .gray_wr_en(gwe_b), .gray_wr_addr(gwa_b),
        .win_rd_en(wre_b), .win_rd_addr(wra_b), .tap_valid(tv_b), .tap_idx(ti_b),
        .pix_wr_en(pwe_b), .pix_wr_addr(pwa_b), .border(bord_b),
        .busy(busy_b), .done(done_b), .phase(ph_b)
    );

    typedef struct packed {
        logic       busy, done;
        logic [1:0] phase;
        logic       grd_vld;
        logic [9:0] grd;
        logic       gwe;
        logic [9:0] gwa;
        logic       wre;
        logic [9:0] wra;
        logic       tv;
        logic [3:0] ti;
        logic       pwe;
        logic [9:0] pwa;
        logic       bord;
        int         pix;
    } rec_t;

    rec_t tr_a[$];
    rec_t tr_b[$];
    logic a_run = 1'b0, b_run = 1'b0;
    int   a_idx = 0, b_idx = 0;
    int   n_chk = 0, n_fail = 0;
    int   frame_cyc = 0;
    int   a_gw, a_bd, a_in, a_done_cyc, b_gw, b_bd, b_in, b_done_cyc, a_done_cnt;
    bit   a_done_seen, b_done_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int sel, input rec_t r);
        if (sel == 0) tr_a.push_back(r);
        else          tr_b.push_back(r);
    endtask

    // One record per clock cycle, from the first gray cycle through the done cycle.
    task automatic build(input int sel, input int w, input int h);
        rec_t r;
        int   n = w * h;
        for (int k = 0; k < n; k++) begin
            r = '0; r.busy = 1; r.phase = 2'd1; r.grd_vld = 1; r.grd = 10'(k);
            if (k > 0) begin r.gwe = 1; r.gwa = 10'(k - 1); end
            push(sel, r);
        end
        r = '0; r.busy = 1; r.phase = 2'd1; r.gwe = 1; r.gwa = 10'(n - 1);
        push(sel, r);
        for (int p = 0; p < n; p++) begin
            int row = p / w;
            int col = p % w;
            if (row == 0 || row == h - 1 || col == 0 || col == w - 1) begin
                r = '0; r.busy = 1; r.phase = 2'd2; r.pwe = 1; r.pwa = 10'(p); r.bord = 1; r.pix = p;
                push(sel, r);
            end else begin
                for (int t = 0; t < 10; t++) begin
                    r = '0; r.busy = 1; r.phase = 2'd2; r.pix = p;
                    if (t < 9) begin
                        r.wre = 1;
                        r.wra = 10'((row + t / 3 - 1) * w + col + t % 3 - 1);
                    end
                    if (t > 0) begin r.tv = 1; r.ti = 4'(t - 1); end
                    push(sel, r);
                end
                r = '0; r.busy = 1; r.phase = 2'd2; r.pwe = 1; r.pwa = 10'(p); r.pix = p;
                push(sel, r);
            end
        end
        r = '0; r.busy = 1; r.done = 1; r.phase = 2'd3;
        push(sel, r);
    endtask

    function automatic logic [63:0] pack_rec(input rec_t r);
        return 64'({r.busy, r.done, r.phase, r.gwe, r.gwa, r.wre, r.wra, r.tv, r.ti,
                    r.pwe, r.pwa, r.bord, r.grd_vld ? r.grd : 10'd0});
    endfunction

    task automatic mstep(inout logic run, inout int idx, input int len);
        if (!run) begin
            if (start) begin run = 1'b1; idx = 0; end
        end else if (abort || idx == len - 1) run = 1'b0;
        else idx++;
    endtask

    task automatic clr_stats();
        frame_cyc = 0; a_gw = 0; a_bd = 0; a_in = 0; a_done_cyc = 0; a_done_seen = 0;
        b_gw = 0; b_bd = 0; b_in = 0; b_done_cyc = 0; b_done_seen = 0; a_done_cnt = 0;
    endtask

    task automatic cycle();
        rec_t ea, eb;
        logic [63:0] oa, ob;
        @(posedge clk);
        if (!rst) begin
            a_run = 1'b0; b_run = 1'b0;
        end else begin
            mstep(a_run, a_idx, tr_a.size());
            mstep(b_run, b_idx, tr_b.size());
        end
        #1;
        frame_cyc++;
        ea = a_run ? tr_a[a_idx] : '0;
        eb = b_run ? tr_b[b_idx] : '0;
        oa = 64'({busy_a, done_a, ph_a, gwe_a, gwe_a ? gwa_a : 10'd0, wre_a, wre_a ? wra_a : 10'd0,
                  tv_a, tv_a ? ti_a : 4'd0, pwe_a, pwe_a ? pwa_a : 10'd0, pwe_a & bord_a,
                  ea.grd_vld ? grd_a : 10'd0});
        ob = 64'({busy_b, done_b, ph_b, gwe_b, gwe_b ? gwa_b : 10'd0, wre_b, wre_b ? wra_b : 10'd0,
                  tv_b, tv_b ? ti_b : 4'd0, pwe_b, pwe_b ? pwa_b : 10'd0, pwe_b & bord_b,
                  eb.grd_vld ? grd_b : 10'd0});
        check($sformatf("a_cyc%0d", frame_cyc), oa, pack_rec(ea));
        check($sformatf("b_cyc%0d", frame_cyc), ob, pack_rec(eb));
        if (done_a) a_done_cnt++;
        if (!a_done_seen) begin
            if (gwe_a) a_gw++;
            if (pwe_a && bord_a) a_bd++;
            if (pwe_a && !bord_a) a_in++;
            if (done_a) begin a_done_seen = 1; a_done_cyc = frame_cyc; end
        end
        if (!b_done_seen) begin
            if (gwe_b) b_gw++;
            if (pwe_b && bord_b) b_bd++;
            if (pwe_b && !bord_b) b_in++;
            if (done_b) begin b_done_seen = 1; b_done_cyc = frame_cyc; end
        end
    endtask

    task automatic check_raw_zero(input string tag);
        check({tag, "_a"}, 64'({busy_a, done_a, ph_a, gwe_a, gwa_a, wre_a, wra_a, tv_a, ti_a,
                                pwe_a, pwa_a, bord_a, grd_a}), 64'd0);
        check({tag, "_b"}, 64'({busy_b, done_b, ph_b, gwe_b, gwa_b, wre_b, wra_b, tv_b, ti_b,
                                pwe_b, pwa_b, bord_b, grd_b}), 64'd0);
    endtask

    task automatic run_abort(input int at_idx);
        clr_stats();
        start = 1'b1;
        cycle();
        start = 1'b0;
        while (frame_cyc < at_idx + 1) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check($sformatf("abort%0d_busy", at_idx), 64'(busy_a), 64'd0);
        repeat (3) cycle();
        check($sformatf("abort%0d_nodone", at_idx), 64'(a_done_cnt), 64'd0);
    endtask

    initial begin
        int p500;
        build(0, 32, 32);
        build(1, 8, 4);

        cycle();
        cycle();
        check_raw_zero("rst_init");
        #3 rst = 1'b1;
        repeat (3) cycle();

        // Full frames on both instances, with stray start pulses while busy.
        clr_stats();
        start = 1'b1;
        cycle();
        for (int i = 0; i < 12000 && !a_done_seen; i++) begin
            start = ($urandom_range(0, 49) == 0);
            cycle();
        end
        start = 1'b0;
        check("a_done_seen", 64'(a_done_seen), 64'd1);
        check("a_done_cyc", 64'(a_done_cyc), 64'd11050);
        check("a_gray_wr", 64'(a_gw), 64'd1024);
        check("a_border_wr", 64'(a_bd), 64'd124);
        check("a_interior_wr", 64'(a_in), 64'd900);
        check("b_done_cyc", 64'(b_done_cyc), 64'd186);
        check("b_gray_wr", 64'(b_gw), 64'd32);
        check("b_border_wr", 64'(b_bd), 64'd20);
        check("b_interior_wr", 64'(b_in), 64'd12);
        repeat (200) cycle();

        // Aborts: gray pass, drain, mid-window of pixel 500, final write, random points.
        p500 = 0;
        for (int i = 0; i < tr_a.size(); i++)
            if (p500 == 0 && tr_a[i].wre && tr_a[i].pix == 500) p500 = i;
        run_abort(40);
        run_abort(1024);
        run_abort(p500 + 4);
        run_abort(tr_a.size() - 2);
        for (int n = 0; n < 3; n++) run_abort($urandom_range(0, 3000));

        // Asynchronous reset mid-gray, then release with start already high.
        clr_stats();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (50) cycle();
        #3 rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy_a), 64'd0);
        check("arst_gwe", 64'(gwe_a), 64'd0);
        check("arst_phase", 64'(ph_a), 64'd0);
        check_raw_zero("arst_all");
        start = 1'b1;
        cycle();
        cycle();
        #2 rst = 1'b1;
        cycle();
        check("rel_start_busy", 64'(busy_a), 64'd1);
        check("rel_start_rd0", 64'({ph_a, grd_a}), 64'({2'd1, 10'd0}));
        start = 1'b0;
        repeat (30) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
